// File: rtl/nvram_uploader_if.sv
// nvram_uploader_if: HPS upload handshake plus shared CMOS RAM port of the NVRAM uploader
interface nvram_uploader_if;
  logic upload_req;
  logic up_rd;
  logic [10:0] up_addr;
  logic [7:0] up_din;
  logic up_wait;
  logic up_done;
  logic proto_err;
  logic cmos_cpu_busy;
  logic cpu_cmos_we;
  logic [9:0] cmos_addr;
  logic cmos_rd;
  logic [3:0] cmos_q;
  logic dirty;
  modport slave (
    input upload_req, up_rd, up_addr, cmos_cpu_busy, cpu_cmos_we, cmos_q,
    output up_din, up_wait, up_done, proto_err, cmos_addr, cmos_rd, dirty
  );
  modport master (
    output upload_req, up_rd, up_addr, cmos_cpu_busy, cpu_cmos_we, cmos_q,
    input up_din, up_wait, up_done, proto_err, cmos_addr, cmos_rd, dirty
  );
endinterface

// File: rtl/nvram_uploader.sv
// nvram_uploader: serves HPS byte reads of the 1024x4 CMOS RAM through a CPU-arbitrated shared port
module nvram_uploader (
  input logic clock_12,
  input logic reset,
  nvram_uploader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARB, ISSUE, CAPTURE} state_t;
  state_t state;
  logic [9:0] addr;
  logic [9:0] addr_q;
  logic req_q;
  logic rd_go;
  assign rd_go = state == ISSUE && bus.upload_req && !bus.cmos_cpu_busy && !reset;
  assign bus.cmos_rd = rd_go;
  assign bus.cmos_addr = rd_go ? addr : addr_q;
  // request sequencing, response capture and sticky status flags
  always_ff @(posedge clock_12) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      addr_q <= '0;
      req_q <= 1'b0;
      bus.up_din <= 8'h00;
      bus.up_wait <= 1'b0;
      bus.up_done <= 1'b0;
      bus.proto_err <= 1'b0;
      bus.dirty <= 1'b0;
    end else begin
      req_q <= bus.upload_req;
      bus.up_done <= 1'b0;
      bus.dirty <= bus.cpu_cmos_we | (bus.dirty & ~bus.up_done);
      bus.proto_err <= (bus.proto_err & ~(bus.upload_req & ~req_q)) | (bus.up_rd && state != IDLE);
      if (rd_go) addr_q <= addr;
      unique case (state)
        IDLE:
          if (bus.up_rd && bus.upload_req) begin
            if (bus.up_addr[10]) bus.up_din <= 8'hFF;
            else begin
              addr <= bus.up_addr[9:0];
              bus.up_wait <= 1'b1;
              state <= ARB;
            end
          end
        ARB:
          if (!bus.upload_req) begin
            state <= IDLE;
            bus.up_wait <= 1'b0;
          end else if (!bus.cmos_cpu_busy) state <= ISSUE;
        ISSUE:
          if (!bus.upload_req) begin
            state <= IDLE;
            bus.up_wait <= 1'b0;
          end else state <= bus.cmos_cpu_busy ? ARB : CAPTURE;
        CAPTURE: begin
          state <= IDLE;
          bus.up_wait <= 1'b0;
          if (bus.upload_req) begin
            bus.up_din <= {4'h0, bus.cmos_q};
            bus.up_done <= addr == 10'h3FF;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nvram_uploader.sv
// tb_nvram_uploader: randomized scoreboard bench for nvram_uploader against a CMOS RAM model
module tb_nvram_uploader;
  logic clk;
  logic rst;
  nvram_uploader_if bus();
  nvram_uploader dut (.clock_12(clk), .reset(rst), .bus(bus));

  typedef struct {
    logic [7:0] din;
    logic done;
    int ew;
    int nrd;
    logic [9:0] addr;
  } item_t;

  item_t sb[$];
  logic [3:0] mem [1024];
  logic [7:0] last_din;
  int checks;
  int failures;
  int done_seen;
  int done_exp;
  int rd_total;
  bit active;
  int wcnt;
  int rcnt;
  logic [9:0] raddr;

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // CMOS RAM: data is valid exactly one cycle after the strobe, garbage otherwise
  initial forever begin
    @(posedge clk);
    bus.cmos_q <= bus.cmos_rd ? mem[bus.cmos_addr] : 4'($urandom);
  end

  // monitor: tracks each accepted request until its response and checks it against the scoreboard
  initial begin
    item_t it;
    active = 0;
    forever begin
      @(negedge clk);
      if (bus.cmos_rd) begin
        rd_total++;
        chk("rd_while_busy", 32'(bus.cmos_cpu_busy), 0);
      end
      if (bus.up_done) done_seen++;
      if (active) begin
        if (bus.up_wait) begin
          wcnt++;
          if (bus.cmos_rd) begin
            rcnt++;
            raddr = bus.cmos_addr;
          end
        end else begin
          active = 0;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow actual=response required=none");
          end else begin
            it = sb.pop_front();
            chk("up_din", 32'(bus.up_din), 32'(it.din));
            chk("up_done", 32'(bus.up_done), 32'(it.done));
            if (it.ew >= 0) chk("wait_cycles", wcnt, it.ew);
            if (it.nrd >= 0) chk("rd_count", rcnt, it.nrd);
            if (it.nrd == 1) chk("rd_addr", 32'(raddr), 32'(it.addr));
          end
        end
      end
      if (!active && bus.up_rd && bus.upload_req && !bus.up_wait && !rst) begin
        active = 1;
        wcnt = 0;
        rcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_up_din"}, 32'(bus.up_din), 0);
    chk({tag, "_up_wait"}, 32'(bus.up_wait), 0);
    chk({tag, "_up_done"}, 32'(bus.up_done), 0);
    chk({tag, "_proto_err"}, 32'(bus.proto_err), 0);
    chk({tag, "_cmos_rd"}, 32'(bus.cmos_rd), 0);
    chk({tag, "_cmos_addr"}, 32'(bus.cmos_addr), 0);
    chk({tag, "_dirty"}, 32'(bus.dirty), 0);
  endtask

  // one HPS read; busy_n<0 means random CPU contention, the *_at arguments inject events k cycles in
  task automatic xfer(input logic [10:0] a, input int busy_n, input int dup_at, input int drop_at,
                      input int rst_at, input bit we_on_done);
    item_t it;
    int k;
    it.addr = a[9:0];
    if (rst_at >= 0) begin
      it.din = 8'h00;
      it.done = 1'b0;
      it.ew = -1;
      it.nrd = -1;
      last_din = 8'h00;
    end else if (drop_at >= 0) begin
      it.din = last_din;
      it.done = 1'b0;
      it.ew = -1;
      it.nrd = 0;
    end else begin
      it.din = a >= 11'd1024 ? 8'hFF : {4'h0, mem[a[9:0]]};
      it.done = a == 11'd1023;
      it.ew = a >= 11'd1024 ? 0 : (busy_n >= 0 ? 3 + busy_n : -1);
      it.nrd = a >= 11'd1024 ? 0 : 1;
      last_din = it.din;
    end
    if (it.done) done_exp++;
    sb.push_back(it);
    bus.up_addr = a;
    bus.up_rd = 1'b1;
    tick();
    bus.up_rd = 1'b0;
    k = 0;
    while (bus.up_wait && k < 400) begin
      bus.cmos_cpu_busy = busy_n < 0 ? ($urandom_range(0, 2) == 0) : (k < busy_n);
      bus.up_rd = k == dup_at;
      if (k == dup_at) bus.up_addr = 11'($urandom);
      if (k == drop_at) bus.upload_req = 1'b0;
      rst = k == rst_at;
      tick();
      k++;
    end
    bus.cmos_cpu_busy = 1'b0;
    bus.up_rd = 1'b0;
    rst = 1'b0;
    if (bus.up_wait) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout actual=up_wait_high required=low addr=%0h", a);
    end
    bus.cpu_cmos_we = we_on_done;
    tick();
    bus.cpu_cmos_we = 1'b0;
  endtask

  // stimulus: directed scenarios, sequential uploads, random traffic, mid-operation reset
  initial begin
    int snap;
    checks = 0;
    failures = 0;
    done_seen = 0;
    done_exp = 0;
    rd_total = 0;
    last_din = 8'h00;
    for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom);
    mem[10'h155] = 4'hA;
    rst = 1'b1;
    bus.upload_req = 1'b0;
    bus.up_rd = 1'b0;
    bus.up_addr = '0;
    bus.cmos_cpu_busy = 1'b0;
    bus.cpu_cmos_we = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();
    bus.up_addr = 11'd5;
    bus.up_rd = 1'b1;
    tick();
    bus.up_rd = 1'b0;
    tick();
    chk("ignored_up_wait", 32'(bus.up_wait), 0);
    chk("ignored_up_din", 32'(bus.up_din), 0);
    bus.upload_req = 1'b1;
    tick();
    xfer(11'h155, 0, -1, -1, -1, 0);
    xfer(11'h2A7, 10, -1, -1, -1, 0);
    xfer(11'h400, 0, -1, -1, -1, 0);
    xfer(11'h7FF, 3, -1, -1, -1, 0);
    xfer(11'h010, 5, 2, -1, -1, 0);
    chk("proto_err_set", 32'(bus.proto_err), 1);
    xfer(11'h3FF, 6, -1, 2, -1, 0);
    chk("abort_up_wait", 32'(bus.up_wait), 0);
    bus.upload_req = 1'b1;
    tick();
    chk("proto_err_clear", 32'(bus.proto_err), 0);
    bus.cpu_cmos_we = 1'b1;
    tick();
    bus.cpu_cmos_we = 1'b0;
    tick();
    chk("dirty_set", 32'(bus.dirty), 1);
    for (int a = 0; a < 1024; a++) xfer(11'(a), 0, -1, -1, -1, 0);
    chk("dirty_cleared", 32'(bus.dirty), 0);
    bus.cpu_cmos_we = 1'b1;
    tick();
    bus.cpu_cmos_we = 1'b0;
    for (int a = 0; a < 1024; a++) xfer(11'(a), -1, -1, -1, -1, a == 1023);
    chk("dirty_kept", 32'(bus.dirty), 1);
    for (int n = 0; n < 80; n++) xfer(11'($urandom_range(0, 1100)), -1, -1, -1, -1, 0);
    xfer(11'h0AB, 0, -1, -1, 1, 0);
    check_reset_vals("midreset");
    snap = rd_total;
    repeat (5) tick();
    chk("no_rd_after_reset", rd_total, snap);
    xfer(11'h155, 0, -1, -1, -1, 0);
    repeat (4) tick();
    chk("sb_drained", sb.size(), 0);
    chk("done_pulses", done_seen, done_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
